round_judge: RTL and testbench
==============================

// Module: round_judge
// PURPOSE
//  Per-round referee that drives the win_count interface from the producer side.
//  - Runs one game round: starts it, times it, and decides win or lose from the game-logic hit flags.
//  - Emits a clean, stretched win pulse; win_count is edge-triggered on win, so glitch-free width matters.
//  - Also emits a lose pulse and round status for the VGA/score display.
//  - Sits between the game-object logic and win_count, inside the game top level.
// PARAMETERS
//  TIME_W       8   width of round timer / time_left
//  TIME_LIMIT   60  round length in tick periods (1..2^TIME_W-1)
//  HOLD_TICKS   3   tick periods spent in result display before returning to IDLE
//  PULSE_CYC    4   clk cycles that win/lose stay high (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-high
//  tick         in   1       1-clk timebase strobe (e.g. 1 Hz enable)
//  start        in   1       level/pulse request to begin a round
//  goal_hit     in   1       player reached goal (sampled each clk)
//  hazard_hit   in   1       player hit hazard (sampled each clk)
//  win          out  1       registered win pulse, PULSE_CYC clks wide
//  lose         out  1       registered lose pulse, PULSE_CYC clks wide
//  round_active out  1       high in PLAY
//  time_left    out  TIME_W  remaining ticks; 0 outside PLAY
//  result       out  2       00 none, 01 win, 10 lose-hazard, 11 lose-timeout
//  streak       out  8       consecutive wins (see CONFIGURATION)
// BEHAVIOUR
//  - Reset state: all outputs 0, FSM in IDLE, pulse counters 0.
//  - Reset mid-round or mid-pulse aborts at once; no win/lose edge is emitted.
//  - FSM states: IDLE, PLAY, WIN_HOLD, LOSE_HOLD.
//  - IDLE:
//    - start=1 -> PLAY next clk; time_left loads TIME_LIMIT; result cleared to 00.
//  - PLAY: priority per clk is hazard_hit > goal_hit > timeout.
//    - hazard_hit -> LOSE_HOLD, result=10.
//    - goal_hit (no hazard) -> WIN_HOLD, result=01.
//    - tick with time_left==1 and no hit -> time_left=0, LOSE_HOLD, result=11.
//    - tick otherwise -> time_left decrements by 1; it never wraps below 0.
//    - start is ignored while in PLAY.
//  - Pulse timing:
//    - Entering WIN_HOLD: win rises on the clk after the decision.
//    - Entering LOSE_HOLD: lose rises on the clk after the decision.
//    - Either pulse stays high exactly PULSE_CYC clks, then 0. One pulse per round; win and lose are never both high.
//  - HOLD states:
//    - time_left forced to 0; result held.
//    - Count HOLD_TICKS tick strobes, then -> IDLE.
//    - start is ignored; hit flags are ignored.
//  - start held high through IDLE re-enters PLAY on the first IDLE clk (auto-replay).
//  - tick and the decision in the same clk: the decision wins; no extra decrement.
// CONFIGURATION
//  ROUND_JUDGE_STREAK_EN defined:
//    - streak +1 on each win decision, saturating at 8'hFF.
//    - streak cleared to 0 on any lose decision.
//    - Reset value 0.
//  ROUND_JUDGE_STREAK_EN undefined:
//    - streak tied to 8'h00; no streak logic.
//    - The port is kept so instantiations do not change.
// STRUCTURE
//  - Package round_judge_pkg:
//    - state encoding (IDLE=0, PLAY=1, WIN_HOLD=2, LOSE_HOLD=3).
//    - result codes RES_NONE/RES_WIN/RES_HAZ/RES_TIME.
//  - One sub-module: pulse_stretch.
//    - Trigger -> PULSE_CYC-wide registered pulse.
//    - Instantiated twice, once for win and once for lose.
// TESTING (TIME_LIMIT=5, HOLD_TICKS=2, PULSE_CYC=4)
//  1 start, goal_hit after 2 ticks -> time_left 5,4,3 then 0; win high 4 clks; result=01; IDLE after 2 ticks.
//  2 start, no hits, 5 ticks -> time_left reaches 0 on 5th tick; lose 4 clks; result=11; win stays 0.
//  3 goal_hit and hazard_hit same clk in PLAY -> lose pulse only; result=10.
//  4 goal_hit same clk as final tick (time_left==1) -> win; result=01; no lose.
//  5 rst asserted on 2nd clk of win pulse -> win 0 immediately; state IDLE; time_left 0; streak 0.
//  6 STREAK_EN: win, win, lose, win -> streak 1,2,0,1; win_count sees exactly 3 rising edges.

Source files
------------

// File: rtl/round_judge_pkg.sv
// rtl/round_judge_pkg.sv - shared state encoding, result codes and helpers for round_judge
package round_judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_WIN_HOLD  = 2'd2,
        ST_LOSE_HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_WIN  = 2'd1,
        RES_HAZ  = 2'd2,
        RES_TIME = 2'd3
    } result_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - turns a one-clk trigger into a registered PULSE_CYC-wide pulse
module pulse_stretch #(
    parameter int PULSE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic kill,
    output logic pulse
);

    localparam int CNT_W = $clog2(PULSE_CYC + 1);

    // cnt holds the clks still owed after the current high one
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (trig) begin
            cnt   <= CNT_W'(PULSE_CYC - 1);
            pulse <= 1'b1;
        end else if (kill) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
            pulse <= 1'b1;
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/round_judge.sv
// rtl/round_judge.sv - per-round referee driving win_count; streak counter built only with ROUND_JUDGE_STREAK_EN
module round_judge
    import round_judge_pkg::*;
#(
    parameter int TIME_W     = 8,
    parameter int TIME_LIMIT = 60,
    parameter int HOLD_TICKS = 3,
    parameter int PULSE_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              goal_hit,
    input  logic              hazard_hit,
    output logic              win,
    output logic              lose,
    output logic              round_active,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        result,
    output logic [7:0]        streak
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t            state, state_n;
    result_t           res_q, res_n;
    logic [TIME_W-1:0] time_q, time_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic              win_dec, lose_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            res_q  <= RES_NONE;
            time_q <= '0;
            hold_q <= '0;
        end else begin
            state  <= state_n;
            res_q  <= res_n;
            time_q <= time_n;
            hold_q <= hold_n;
        end
    end

    always_comb begin
        state_n  = state;
        res_n    = res_q;
        time_n   = time_q;
        hold_n   = hold_q;
        win_dec  = 1'b0;
        lose_dec = 1'b0;
        case (state)
            ST_IDLE: begin
                time_n = '0;
                hold_n = '0;
                if (start) begin
                    state_n = ST_PLAY;
                    time_n  = TIME_W'(TIME_LIMIT);
                    res_n   = RES_NONE;
                end
            end
            ST_PLAY: begin
                // A hit in the same clk as a tick takes precedence over the countdown
                if (hazard_hit) begin
                    state_n  = ST_LOSE_HOLD;
                    res_n    = RES_HAZ;
                    time_n   = '0;
                    hold_n   = '0;
                    lose_dec = 1'b1;
                end else if (goal_hit) begin
                    state_n = ST_WIN_HOLD;
                    res_n   = RES_WIN;
                    time_n  = '0;
                    hold_n  = '0;
                    win_dec = 1'b1;
                end else if (tick) begin
                    if (time_q <= TIME_W'(1)) begin
                        state_n  = ST_LOSE_HOLD;
                        res_n    = RES_TIME;
                        time_n   = '0;
                        hold_n   = '0;
                        lose_dec = 1'b1;
                    end else begin
                        time_n = time_q - 1'b1;
                    end
                end
            end
            ST_WIN_HOLD, ST_LOSE_HOLD: begin
                time_n = '0;
                if (tick) begin
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        state_n = ST_IDLE;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                time_n  = '0;
                hold_n  = '0;
            end
        endcase
    end

    assign round_active = (state == ST_PLAY);
    assign time_left    = time_q;
    assign result       = res_q;

    // Each decision cancels the other pulse so win and lose can never overlap
    pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_win_pulse (
        .clk   (clk),
        .rst   (rst),
        .trig  (win_dec),
        .kill  (lose_dec),
        .pulse (win)
    );

    pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_lose_pulse (
        .clk   (clk),
        .rst   (rst),
        .trig  (lose_dec),
        .kill  (win_dec),
        .pulse (lose)
    );

`ifdef ROUND_JUDGE_STREAK_EN
    logic [7:0] streak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= 8'h00;
        end else if (lose_dec) begin
            streak_q <= 8'h00;
        end else if (win_dec) begin
            streak_q <= sat_inc8(streak_q);
        end
    end

    assign streak = streak_q;
`else
    assign streak = 8'h00;
`endif

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - randomized and directed rounds checked against an outcome model
module tb_round_judge;

    localparam int TL = 5;
    localparam int HT = 2;
    localparam int PC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       goal_hit = 1'b0;
    logic       hazard_hit = 1'b0;
    logic       win, lose, round_active;
    logic [7:0] time_left;
    logic [1:0] result;
    logic [7:0] streak;

    int passes = 0;
    int total = 0;
    int cyc = 0;
    int win_start = -1000;
    int lose_start = -1000;
    int strk = 0;
    int exp_active = 0;
    int exp_time = 0;
    int exp_res = 0;
    int win_edges = 0;
    int base_edges = 0;

    round_judge #(
        .TIME_W     (8),
        .TIME_LIMIT (TL),
        .HOLD_TICKS (HT),
        .PULSE_CYC  (PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .goal_hit     (goal_hit),
        .hazard_hit   (hazard_hit),
        .win          (win),
        .lose         (lose),
        .round_active (round_active),
        .time_left    (time_left),
        .result       (result),
        .streak       (streak)
    );

    always #5 clk = ~clk;

    always @(posedge win) win_edges++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Pulses are high for the PC clks starting at the decision edge, unless a later decision took over
    task automatic check_all(input string tag);
        int ew;
        int el;
        int es;
        ew = ((cyc - win_start) < PC && win_start > lose_start) ? 1 : 0;
        el = ((cyc - lose_start) < PC && lose_start > win_start) ? 1 : 0;
`ifdef ROUND_JUDGE_STREAK_EN
        es = strk;
`else
        es = 0;
`endif
        check({tag, "_active"}, round_active, exp_active);
        check({tag, "_time"}, time_left, exp_time);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_win"}, win, ew);
        check({tag, "_lose"}, lose, el);
        check({tag, "_streak"}, streak, es);
    endtask

    task automatic record(input int out);
        if (out == 1) begin
            win_start = cyc;
            if (strk < 255) strk = strk + 1;
        end else begin
            lose_start = cyc;
            strk = 0;
        end
    endtask

    // mode 0 random, 1 goal+hazard together, 2 goal on final tick, 3 timeout, 4 immediate goal
    task automatic run_round(input int mode);
        int   ticks;
        int   hold;
        int   phase;
        int   out;
        logic tk, gl, hz;
        ticks = 0;
        hold  = 0;
        start      = 1'b1;
        tick       = 1'($urandom_range(0, 1));
        goal_hit   = 1'($urandom_range(0, 1));
        hazard_hit = 1'($urandom_range(0, 1));
        step();
        phase      = 1;
        exp_active = 1;
        exp_time   = TL;
        exp_res    = 0;
        check_all("start");
        for (int k = 1; k < 300 && phase != 0; k++) begin
            tk = ($urandom_range(0, 2) == 0);
            gl = ($urandom_range(0, 19) == 0);
            hz = ($urandom_range(0, 24) == 0);
            case (mode)
                1: begin gl = (k == 2); hz = (k == 2); end
                2: begin hz = 1'b0; gl = tk && (TL - ticks == 1); end
                3: begin gl = 1'b0; hz = 1'b0; end
                4: begin gl = (k == 1); hz = 1'b0; end
                default: ;
            endcase
            tick       = tk;
            goal_hit   = gl;
            hazard_hit = hz;
            start      = 1'($urandom_range(0, 1));
            step();
            if (phase == 1) begin
                out = 0;
                if (hz) out = 2;
                else if (gl) out = 1;
                else if (tk && (TL - ticks == 1)) out = 3;
                else if (tk) ticks++;
                if (out != 0) begin
                    phase      = 2;
                    hold       = 0;
                    exp_active = 0;
                    exp_time   = 0;
                    exp_res    = out;
                    record(out);
                end else begin
                    exp_time = TL - ticks;
                end
            end else if (tk) begin
                hold++;
                if (hold == HT) phase = 0;
            end
            check_all("round");
        end
        if (phase != 0) check("round_bound", phase, 0);
        start      = 1'b0;
        tick       = 1'b0;
        goal_hit   = 1'b0;
        hazard_hit = 1'b0;
        step();
        check_all("idle");
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        step();
        check_all("post_reset");

        base_edges = win_edges;
        run_round(4);
        run_round(4);
        run_round(3);
        run_round(4);
        check("win_edges", win_edges - base_edges, 3);

        run_round(1);
        run_round(2);
        run_round(3);

        start = 1'b1;
        step();
        exp_active = 1;
        exp_time   = TL;
        exp_res    = 0;
        check_all("rst_play");
        start    = 1'b0;
        goal_hit = 1'b1;
        step();
        record(1);
        exp_active = 0;
        exp_time   = 0;
        exp_res    = 1;
        check_all("rst_win1");
        goal_hit = 1'b0;
        step();
        check_all("rst_win2");
        rst = 1'b1;
        #1;
        win_start  = -1000;
        lose_start = -1000;
        strk       = 0;
        exp_active = 0;
        exp_time   = 0;
        exp_res    = 0;
        check_all("rst_async");
        #2;
        rst = 1'b0;
        step();
        check_all("rst_after");

        for (int r = 0; r < 30; r++) begin
            run_round((r % 3 == 0) ? int'($urandom_range(0, 4)) : 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
